regfile_wb_sched: RTL

//  Write-port scheduler and scoreboard for the 8x16 register file (SR1/SR2 read, DR/DR_IN/LD write).
//  - Arbitrates the single write port between two writeback sources: A = ALU, B = memory load.
//  - Uses valid/ready handshakes and round-robin arbitration.
//  - Keeps a per-register pending bit so issue logic can stall on RAW hazards and block WAW.
//  - Drives DR, DR_IN and LD of the register file from registered outputs.

---
 rtl/regfile_wb_sched.sv | 96 +++++++++
 1 files changed

// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and RAW/WAW scoreboard for the 8x16 register file.
// Round-robin arbitration between ALU (A) and load (B) writeback sources.
module regfile_wb_sched #(
  parameter  int DATA_SIZE = 16,
  parameter  int ADDR_SIZE = 3,
  localparam int NREG      = 2 ** ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_valid,
  input  logic [ADDR_SIZE-1:0] alloc_dr,
  output logic                 alloc_ready,
  input  logic [ADDR_SIZE-1:0] sr1,
  input  logic [ADDR_SIZE-1:0] sr2,
  output logic                 sr1_busy,
  output logic                 sr2_busy,
  input  logic                 a_valid,
  input  logic [ADDR_SIZE-1:0] a_dr,
  input  logic [DATA_SIZE-1:0] a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_SIZE-1:0] b_dr,
  input  logic [DATA_SIZE-1:0] b_data,
  output logic                 b_ready,
  output logic [ADDR_SIZE-1:0] rf_dr,
  output logic [DATA_SIZE-1:0] rf_dr_in,
  output logic                 rf_ld,
  output logic [NREG-1:0]      pending,
  output logic                 wb_err
);

  // 1 when B won the most recent transfer
  logic                 last_b;
  logic                 xfer;
  logic [ADDR_SIZE-1:0] win_dr;
  logic [DATA_SIZE-1:0] win_data;
  logic [NREG-1:0]      pending_nxt;

  assign alloc_ready = ~pending[alloc_dr];
  assign sr1_busy    = pending[sr1];
  assign sr2_busy    = pending[sr2];

  // Round robin: on contention the source that did not win last time goes
  assign a_ready = a_valid & (~b_valid | last_b);
  assign b_ready = b_valid & (~a_valid | ~last_b);
  assign xfer    = a_ready | b_ready;

  // Select destination and data of the granted source
  always_comb begin
    win_dr   = '0;
    win_data = '0;
    unique case (1'b1)
      a_ready: begin
        win_dr   = a_dr;
        win_data = a_data;
      end
      b_ready: begin
        win_dr   = b_dr;
        win_data = b_data;
      end
      default: ;
    endcase
  end

  // Clear on the presented write, then set on reservation (set wins)
  always_comb begin
    pending_nxt = pending;
    if (rf_ld)
      pending_nxt[rf_dr] = 1'b0;
    if (alloc_valid && alloc_ready)
      pending_nxt[alloc_dr] = 1'b1;
  end

  // Registered write port, arbitration history and scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_ld    <= 1'b0;
      rf_dr    <= '0;
      rf_dr_in <= '0;
      last_b   <= 1'b1;
      pending  <= '0;
      wb_err   <= 1'b0;
    end else begin
      rf_ld   <= xfer;
      pending <= pending_nxt;
      if (xfer) begin
        rf_dr    <= win_dr;
        rf_dr_in <= win_data;
        last_b   <= b_ready;
        if (!pending[win_dr])
          wb_err <= 1'b1;
      end
    end
  end

endmodule
